// File: rtl/bsg_fifo_1r1w_rolly_multi.sv
// Multi-channel rollback FIFO: independent write/read checkpointed queues, one per channel,
// statically partitioned over a single shared 1r1w memory.
module bsg_fifo_1r1w_rolly_multi #(
  parameter int unsigned width_p    = 1,
  parameter int unsigned lg_size_p  = 1,
  parameter int unsigned num_chan_p = 2,
  localparam int unsigned chan_w    = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,

  input  logic [chan_w-1:0]                     w_chan_i,
  input  logic                                  v_i,
  input  logic [width_p-1:0]                    data_i,
  output logic                                  ready_o,
  input  logic                                  w_commit_i,
  input  logic                                  w_drop_i,
  input  logic                                  w_clear_i,

  input  logic [chan_w-1:0]                     r_chan_i,
  output logic                                  v_o,
  output logic [width_p-1:0]                    data_o,
  input  logic                                  yumi_i,
  input  logic                                  r_commit_i,
  input  logic                                  r_rewind_i,

  output logic [num_chan_p*(lg_size_p+1)-1:0]   count_o
);

  localparam int unsigned ptr_w  = lg_size_p + 1;
  localparam int unsigned addr_w = chan_w + lg_size_p;
  // Pointer arrays cover every encodable channel so any index stays in range.
  localparam int unsigned slots  = 1 << chan_w;
  localparam logic [ptr_w-1:0] size_lp = ptr_w'(1 << lg_size_p);

  logic [ptr_w-1:0] wptr    [slots];
  logic [ptr_w-1:0] wcptr   [slots];
  logic [ptr_w-1:0] rptr    [slots];
  logic [ptr_w-1:0] rcptr   [slots];
  logic [ptr_w-1:0] wptr_n  [slots];
  logic [ptr_w-1:0] wcptr_n [slots];
  logic [ptr_w-1:0] rptr_n  [slots];
  logic [ptr_w-1:0] rcptr_n [slots];

  logic [width_p-1:0] mem [1 << addr_w];

  logic [ptr_w-1:0]  w_occ;
  logic              w_full;
  logic              enq;
  logic [addr_w-1:0] waddr;
  logic [addr_w-1:0] raddr;

  // Occupancy is measured against the read checkpoint: reads free space only on commit.
  assign w_occ   = wptr[w_chan_i] - rcptr[w_chan_i];
  assign w_full  = (w_occ == size_lp);
  assign ready_o = ~w_full;
  assign enq     = v_i & ~w_full & ~w_clear_i & ~w_drop_i;

  assign v_o    = (rptr[r_chan_i] != wcptr[r_chan_i]);
  assign waddr  = {w_chan_i, wptr[w_chan_i][lg_size_p-1:0]};
  assign raddr  = {r_chan_i, rptr[r_chan_i][lg_size_p-1:0]};
  assign data_o = mem[raddr];

  always_comb begin
    for (int c = 0; c < slots; c++) begin
      wptr_n[c]  = wptr[c];
      wcptr_n[c] = wcptr[c];
      rptr_n[c]  = rptr[c];
      rcptr_n[c] = rcptr[c];

      if (chan_w'(c) == r_chan_i) begin
        if (r_rewind_i) begin
          rptr_n[c] = rcptr[c];
        end else begin
          rptr_n[c] = rptr[c] + ptr_w'(yumi_i);
          if (r_commit_i) rcptr_n[c] = rptr_n[c];
        end
      end

      // Write side resolves after read side so clear lands on this cycle's read position.
      if (chan_w'(c) == w_chan_i) begin
        if (w_clear_i) begin
          wptr_n[c]  = rptr_n[c];
          wcptr_n[c] = rptr_n[c];
        end else if (w_drop_i) begin
          wptr_n[c] = wcptr[c];
        end else begin
          wptr_n[c] = wptr[c] + ptr_w'(enq);
          if (w_commit_i) wcptr_n[c] = wptr_n[c];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < slots; c++) begin
      if (!reset_n_i) begin
        wptr[c]  <= '0;
        wcptr[c] <= '0;
        rptr[c]  <= '0;
        rcptr[c] <= '0;
      end else begin
        wptr[c]  <= wptr_n[c];
        wcptr[c] <= wcptr_n[c];
        rptr[c]  <= rptr_n[c];
        rcptr[c] <= rcptr_n[c];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && enq) mem[waddr] <= data_i;
  end

  always_comb begin
    count_o = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      count_o[c*ptr_w +: ptr_w] = wptr[c] - rcptr[c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o)) else $error("yumi_i asserted without v_o");
      assert (int'(w_chan_i) < int'(num_chan_p)) else $error("w_chan_i out of range");
      assert (int'(r_chan_i) < int'(num_chan_p)) else $error("r_chan_i out of range");
    end
  end

  // Ordering rcptr <= rptr <= wcptr <= wptr, expressed as distances from rcptr.
  for (genvar g = 0; g < num_chan_p; g++) begin : g_inv
    logic [ptr_w-1:0] d_r, d_wc, d_w;
    assign d_r  = rptr[g]  - rcptr[g];
    assign d_wc = wcptr[g] - rcptr[g];
    assign d_w  = wptr[g]  - rcptr[g];
    always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
        assert (d_r <= d_wc && d_wc <= d_w && d_w <= size_lp)
          else $error("pointer ordering violated on channel %0d", g);
      end
    end
  end

endmodule
